// File: rtl/rv32i_boot_controller_if.sv
// Load-stream and memory-write bundle of the rv32i boot controller.
// The master side feeds program words and watches the IMEM/DMEM write
// ports. The slave side is the controller itself.
interface rv32i_boot_controller_if #(
   parameter int XLEN    = 32,
   parameter int IMEM_AW = 10,
   parameter int DMEM_AW = 12
);
   logic               ld_valid;
   logic               ld_ready;
   logic [XLEN-1:0]    ld_data;
   logic               ld_last;
   logic               imem_we;
   logic [IMEM_AW-1:0] imem_addr;
   logic [XLEN-1:0]    imem_wdata;
   logic               dmem_we;
   logic [DMEM_AW-1:0] dmem_addr;

   modport master (
      output ld_valid, ld_data, ld_last,
      input  ld_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr
   );

   modport slave (
      input  ld_valid, ld_data, ld_last,
      output ld_ready, imem_we, imem_addr, imem_wdata, dmem_we, dmem_addr
   );
endinterface

// File: rtl/rv32i_boot_controller.sv
// rv32i boot controller: streams a program into IMEM while the core is held
// in reset, optionally zero-fills DMEM, then releases the core and watches
// its PC until it parks on one address (halt) or the run-cycle budget
// expires (timeout).
// Optional feature macro: DMEM_CLEAR_EN (adds the DMEM zero-fill pass).
module rv32i_boot_controller #(
   parameter int XLEN        = 32,
   parameter int IMEM_AW     = 10,
   parameter int DMEM_AW     = 12,
   parameter int HALT_CYCLES = 8,
   parameter int MAX_CYCLES  = 1000,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  restart,
   rv32i_boot_controller_if.slave bus,
   output logic                  core_rst,
   input  logic [XLEN-1:0]       pc_in,
   output logic [CNT_W-1:0]      cycle_cnt,
   output logic [IMEM_AW:0]      ld_cnt,
   output logic                  ld_ovf,
   output logic                  done,
   output logic                  halted,
   output logic                  timeout
);

   typedef enum logic [1:0] {ST_LOAD, ST_CLEAR, ST_RUN, ST_DONE} state_t;

   localparam int SW = $clog2(HALT_CYCLES) + 1;
   localparam logic [IMEM_AW:0] IMEM_DEPTH = (IMEM_AW+1)'(1 << IMEM_AW);
   localparam logic [SW-1:0]    STABLE_LIM = SW'(HALT_CYCLES - 2);
   localparam logic [CNT_W-1:0] CYCLE_LIM  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CYCLE_SAT  = {CNT_W{1'b1}};

   state_t             state_reg, state_next;
   logic [IMEM_AW:0]   ld_cnt_reg, ld_cnt_next;
   logic               ld_ovf_reg, ld_ovf_next;
   logic               imem_we_reg, imem_we_next;
   logic [IMEM_AW-1:0] imem_addr_reg, imem_addr_next;
   logic [XLEN-1:0]    imem_wdata_reg, imem_wdata_next;
   logic [CNT_W-1:0]   cycle_cnt_reg, cycle_cnt_next;
   logic [XLEN-1:0]    pc_q_reg, pc_q_next;
   logic               pc_valid_reg, pc_valid_next;
   logic [SW-1:0]      stable_cnt_reg, stable_cnt_next;
   logic               halted_reg, halted_next;
   logic               timeout_reg, timeout_next;
   logic               pc_match;
`ifdef DMEM_CLEAR_EN
   logic [DMEM_AW-1:0] clr_cnt_reg, clr_cnt_next;
`endif

   // State register; reset and restart both return everything to LOAD.
   always_ff @(posedge clk) begin
      if (reset || restart) begin
         state_reg      <= ST_LOAD;
         ld_cnt_reg     <= '0;
         ld_ovf_reg     <= 1'b0;
         imem_we_reg    <= 1'b0;
         imem_addr_reg  <= '0;
         imem_wdata_reg <= '0;
         cycle_cnt_reg  <= '0;
         pc_q_reg       <= '0;
         pc_valid_reg   <= 1'b0;
         stable_cnt_reg <= '0;
         halted_reg     <= 1'b0;
         timeout_reg    <= 1'b0;
`ifdef DMEM_CLEAR_EN
         clr_cnt_reg    <= '0;
`endif
      end else begin
         state_reg      <= state_next;
         ld_cnt_reg     <= ld_cnt_next;
         ld_ovf_reg     <= ld_ovf_next;
         imem_we_reg    <= imem_we_next;
         imem_addr_reg  <= imem_addr_next;
         imem_wdata_reg <= imem_wdata_next;
         cycle_cnt_reg  <= cycle_cnt_next;
         pc_q_reg       <= pc_q_next;
         pc_valid_reg   <= pc_valid_next;
         stable_cnt_reg <= stable_cnt_next;
         halted_reg     <= halted_next;
         timeout_reg    <= timeout_next;
`ifdef DMEM_CLEAR_EN
         clr_cnt_reg    <= clr_cnt_next;
`endif
      end
   end

   // Next-state logic: load acceptance, DMEM clear sweep, run monitoring.
   always_comb begin
      state_next      = state_reg;
      ld_cnt_next     = ld_cnt_reg;
      ld_ovf_next     = ld_ovf_reg;
      imem_we_next    = 1'b0;
      imem_addr_next  = imem_addr_reg;
      imem_wdata_next = imem_wdata_reg;
      cycle_cnt_next  = cycle_cnt_reg;
      pc_q_next       = pc_q_reg;
      pc_valid_next   = pc_valid_reg;
      stable_cnt_next = stable_cnt_reg;
      halted_next     = halted_reg;
      timeout_next    = timeout_reg;
      // The very first RUN cycle has no previous PC to compare against.
      pc_match        = pc_valid_reg && (pc_in == pc_q_reg);
`ifdef DMEM_CLEAR_EN
      clr_cnt_next    = clr_cnt_reg;
`endif
      case (state_reg)
         ST_LOAD: begin
            if (bus.ld_valid) begin
               if (ld_cnt_reg < IMEM_DEPTH) begin
                  imem_we_next    = 1'b1;
                  imem_addr_next  = ld_cnt_reg[IMEM_AW-1:0];
                  imem_wdata_next = bus.ld_data;
                  ld_cnt_next     = ld_cnt_reg + 1'b1;
               end else begin
                  // IMEM full: drop the word, flag it, keep the count pinned.
                  ld_ovf_next = 1'b1;
               end
               if (bus.ld_last) begin
                  pc_valid_next   = 1'b0;
                  stable_cnt_next = '0;
`ifdef DMEM_CLEAR_EN
                  clr_cnt_next    = '0;
                  state_next      = ST_CLEAR;
`else
                  state_next      = ST_RUN;
`endif
               end
            end
         end
`ifdef DMEM_CLEAR_EN
         ST_CLEAR: begin
            if (clr_cnt_reg == {DMEM_AW{1'b1}}) begin
               state_next = ST_RUN;
            end else begin
               clr_cnt_next = clr_cnt_reg + 1'b1;
            end
         end
`endif
         ST_RUN: begin
            if (cycle_cnt_reg != CYCLE_SAT) begin
               cycle_cnt_next = cycle_cnt_reg + 1'b1;
            end
            pc_q_next       = pc_in;
            pc_valid_next   = 1'b1;
            stable_cnt_next = pc_match ? stable_cnt_reg + 1'b1 : '0;
            // Halt takes priority over a timeout landing on the same cycle.
            if (pc_match && (stable_cnt_reg == STABLE_LIM)) begin
               halted_next = 1'b1;
               state_next  = ST_DONE;
            end else if (cycle_cnt_reg == CYCLE_LIM) begin
               timeout_next = 1'b1;
               state_next   = ST_DONE;
            end
         end
         default: ;
      endcase
   end

   // Output decode; the core stays out of reset in DONE for inspection.
   always_comb begin
      bus.ld_ready   = (state_reg == ST_LOAD);
      core_rst       = (state_reg == ST_LOAD) || (state_reg == ST_CLEAR);
      bus.imem_we    = imem_we_reg;
      bus.imem_addr  = imem_addr_reg;
      bus.imem_wdata = imem_wdata_reg;
`ifdef DMEM_CLEAR_EN
      bus.dmem_we    = (state_reg == ST_CLEAR);
      bus.dmem_addr  = (state_reg == ST_CLEAR) ? clr_cnt_reg : {DMEM_AW{1'b0}};
`else
      bus.dmem_we    = 1'b0;
      bus.dmem_addr  = {DMEM_AW{1'b0}};
`endif
      cycle_cnt      = cycle_cnt_reg;
      ld_cnt         = ld_cnt_reg;
      ld_ovf         = ld_ovf_reg;
      done           = (state_reg == ST_DONE);
      halted         = halted_reg;
      timeout        = timeout_reg;
   end

endmodule

// File: tb/tb_rv32i_boot_controller.sv
// Testbench for rv32i_boot_controller: directed program/halt/timeout/overflow/
// restart scenarios plus a randomized phase, all checked cycle by cycle
// against a behavioural model of the controller.
module tb_rv32i_boot_controller;
   localparam int XLEN        = 32;
   localparam int IMEM_AW     = 4;
   localparam int DMEM_AW     = 12;
   localparam int HALT_CYCLES = 8;
   localparam int MAX_CYCLES  = 50;
   localparam int CNT_W       = 32;
   localparam int DEPTH       = 1 << IMEM_AW;
   localparam int DMEM_DEPTH  = 1 << DMEM_AW;
   localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;
`ifdef DMEM_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset, restart, core_rst;
   logic [XLEN-1:0]    pc_in;
   logic [CNT_W-1:0]   cycle_cnt;
   logic [IMEM_AW:0]   ld_cnt;
   logic               ld_ovf, done, halted, timeout;

   rv32i_boot_controller_if #(.XLEN(XLEN), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW)) bus ();

   rv32i_boot_controller #(
      .XLEN(XLEN), .IMEM_AW(IMEM_AW), .DMEM_AW(DMEM_AW),
      .HALT_CYCLES(HALT_CYCLES), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .restart(restart), .bus(bus),
      .core_rst(core_rst), .pc_in(pc_in), .cycle_cnt(cycle_cnt),
      .ld_cnt(ld_cnt), .ld_ovf(ld_ovf), .done(done),
      .halted(halted), .timeout(timeout)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: phase 0=loading 1=clearing 2=running 3=finished.
   bit          m_valid = 1'b0;
   int          m_phase, m_ld, m_clr;
   bit          m_ovf, m_wr, m_halt, m_to;
   int          m_wa;
   logic [31:0] m_wd;
   longint      m_cyc;
   logic [31:0] pc_hist[$];

   // Logs of what the DUT actually wrote, checked against literals later.
   int          wr_addr_log[$];
   logic [31:0] wr_data_log[$];
   int          dmem_cnt = 0;

   always @(posedge clk) begin
      bit r, rs, v, l, hold;
      logic [31:0] d, p;
      r = reset; rs = restart; v = bus.ld_valid; l = bus.ld_last;
      d = bus.ld_data; p = pc_in;
      if (r || rs) begin
         m_valid = 1'b1; m_phase = 0; m_ld = 0; m_ovf = 1'b0; m_wr = 1'b0;
         m_cyc = 0; m_halt = 1'b0; m_to = 1'b0; m_clr = 0; pc_hist.delete();
      end else if (m_valid) begin
         m_wr = 1'b0;
         case (m_phase)
            0: if (v) begin
               if (m_ld < DEPTH) begin
                  m_wr = 1'b1; m_wa = m_ld; m_wd = d; m_ld++;
               end else begin
                  m_ovf = 1'b1;
               end
               if (l) begin
                  m_phase = CLEAR_EN ? 1 : 2;
                  m_clr = 0;
                  pc_hist.delete();
               end
            end
            1: if (m_clr == DMEM_DEPTH - 1) m_phase = 2; else m_clr++;
            2: begin
               if (m_cyc < CNT_MAX) m_cyc++;
               pc_hist.push_back(p);
               if (pc_hist.size() > HALT_CYCLES) void'(pc_hist.pop_front());
               hold = (pc_hist.size() == HALT_CYCLES);
               foreach (pc_hist[i]) if (pc_hist[i] != p) hold = 1'b0;
               if (hold) begin
                  m_halt = 1'b1; m_phase = 3;
               end else if (m_cyc == MAX_CYCLES) begin
                  m_to = 1'b1; m_phase = 3;
               end
            end
            default: ;
         endcase
      end
      #1;
      if (bus.imem_we === 1'b1) begin
         wr_addr_log.push_back(int'(bus.imem_addr));
         wr_data_log.push_back(bus.imem_wdata);
      end
      if (bus.dmem_we === 1'b1) dmem_cnt++;
      if (m_valid) begin
         chk("core_rst", core_rst, m_phase < 2);
         chk("ld_ready", bus.ld_ready, m_phase == 0);
         chk("imem_we", bus.imem_we, m_wr);
         if (m_wr) begin
            chk("imem_addr", bus.imem_addr, m_wa);
            chk("imem_wdata", bus.imem_wdata, m_wd);
         end
         chk("dmem_we", bus.dmem_we, m_phase == 1);
         chk("dmem_addr", bus.dmem_addr, (m_phase == 1) ? m_clr : 0);
         chk("cycle_cnt", cycle_cnt, m_cyc);
         chk("ld_cnt", ld_cnt, m_ld);
         chk("ld_ovf", ld_ovf, m_ovf);
         chk("done", done, m_phase == 3);
         chk("halted", halted, m_halt);
         chk("timeout", timeout, m_to);
      end
   end

   logic [31:0] prog [6] = '{32'h00500093, 32'h00700113, 32'h002081b3,
                             32'h00302023, 32'h00001017, 32'h0000006f};
   logic [31:0] pcs  [13] = '{32'h0, 32'h4, 32'h8, 32'hc, 32'h10, 32'h14, 32'h14,
                              32'h14, 32'h14, 32'h14, 32'h14, 32'h14, 32'h14};

   task automatic send_word(input logic [31:0] w, input logic last);
      while ($urandom_range(0, 2) == 0) begin
         bus.ld_valid = 1'b0;
         @(negedge clk);
      end
      bus.ld_valid = 1'b1; bus.ld_data = w; bus.ld_last = last;
      @(negedge clk);
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = $urandom;
   endtask

   task automatic wait_run();
      int k = 0;
      while (core_rst !== 1'b0 && k < 6000) begin
         @(negedge clk);
         k++;
      end
      chk("run_entry_bound", k < 6000, 1);
   endtask

   task automatic do_restart();
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   initial begin
      int w0, d0, k;
      reset = 1'b1; restart = 1'b0; pc_in = '0;
      bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_last = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_core_rst", core_rst, 1);
      chk("rst_ld_ready", bus.ld_ready, 1);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_ld_cnt", ld_cnt, 0);
      chk("rst_flags", {ld_ovf, done, halted, timeout, bus.imem_we, bus.dmem_we}, 0);
      reset = 1'b0;
      @(negedge clk);

      // Program load of six words, then release.
      w0 = wr_addr_log.size(); d0 = dmem_cnt;
      for (int i = 0; i < 6; i++) send_word(prog[i], i == 5);
      wait_run();
      chk("t1_ld_cnt", ld_cnt, 6);
      chk("t1_writes", wr_addr_log.size() - w0, 6);
      for (int i = 0; i < 6; i++) begin
         chk("t1_addr", wr_addr_log[w0 + i], i);
         chk("t1_data", wr_data_log[w0 + i], prog[i]);
      end
      chk("t6_dmem_writes", dmem_cnt - d0, CLEAR_EN ? DMEM_DEPTH : 0);

      // PC parks at 0x14: halt on the eighth cycle there.
      for (int i = 0; i < 13; i++) begin
         if (i == 12) chk("t2_not_done_early", done, 0);
         pc_in = pcs[i];
         @(negedge clk);
      end
      chk("t2_done", done, 1);
      chk("t2_halted", halted, 1);
      chk("t2_timeout", timeout, 0);
      chk("t2_cycle_cnt", cycle_cnt, 13);
      for (int i = 0; i < 5; i++) begin
         pc_in = $urandom;
         @(negedge clk);
      end
      chk("t2_cycle_frozen", cycle_cnt, 13);

      // Ever-moving PC: timeout after MAX_CYCLES run cycles.
      do_restart();
      send_word(32'h13, 1'b0);
      send_word(32'h6f, 1'b1);
      wait_run();
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         pc_in = pc_in + 4;
         @(negedge clk);
         k++;
      end
      chk("t3_done", done, 1);
      chk("t3_timeout", timeout, 1);
      chk("t3_halted", halted, 0);
      chk("t3_cycle_cnt", cycle_cnt, 50);

      // Restart in the middle of a run.
      do_restart();
      send_word(32'h6f, 1'b1);
      wait_run();
      for (int i = 0; i < 10; i++) begin
         pc_in = pc_in + 4;
         @(negedge clk);
      end
      do_restart();
      chk("t5_core_rst", core_rst, 1);
      chk("t5_ld_ready", bus.ld_ready, 1);
      chk("t5_cycle_cnt", cycle_cnt, 0);
      chk("t5_flags", {ld_ovf, done, halted, timeout}, 0);

      // Seventeen words into a sixteen-word IMEM.
      w0 = wr_addr_log.size();
      for (int i = 0; i < 17; i++) send_word($urandom, i == 16);
      chk("t4_ld_ovf", ld_ovf, 1);
      chk("t4_ld_cnt", ld_cnt, 16);
      chk("t4_writes", wr_addr_log.size() - w0, 16);
      wait_run();
      chk("t4_running", {core_rst, done}, 0);

      // Randomized traffic checked by the model.
      do_restart();
      for (int c = 0; c < 8000; c++) begin
         bus.ld_valid = $urandom_range(0, 1) == 1;
         bus.ld_data  = $urandom;
         bus.ld_last  = $urandom_range(0, 9) == 0;
         if ($urandom_range(0, 7) == 0) pc_in = 32'($urandom_range(0, 3)) << 2;
         restart = $urandom_range(0, 149) == 0;
         @(negedge clk);
      end
      restart = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
